afifo_rd_stage: RTL



---
 rtl/afifo_rd_stage_if.sv | 27 ++
 rtl/afifo_rd_stage.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/afifo_rd_stage_if.sv
// afifo_rd_stage_if
//   Valid/ready output stream of the asynchronous FIFO read stage.
//   Parameter DSIZE : word width.
//   Signals:
//     m_valid : word present on m_data (driven by the producer)
//     m_ready : consumer accepts the word this cycle
//     m_data  : output word
//   Modports: master (producer, the read stage), slave (consumer).
interface afifo_rd_stage_if #(
  parameter int DSIZE = 8
);
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/afifo_rd_stage.sv
// afifo_rd_stage
//   Read-domain output stage of the asynchronous FIFO bridge. Pops words from
//   the FIFO memory whenever it is non-empty and the 2-entry output buffer has
//   room, and presents them in order on a valid/ready stream. Optionally
//   reports the read-side occupancy computed from the Gray pointers.
//
//   Optional feature macro: AFIFO_RD_LEVEL_EN
//     defined   : rlevel / ralmost_empty computed from rq2_wptr and rptr
//     undefined : rlevel tied to 0, ralmost_empty tied to 1
//
//   Ports:
//     rclk, rrst_n   : read clock, asynchronous active-low reset
//     rempty         : registered empty flag from the read-pointer block
//     rdata          : memory read data for the current read address
//     rptr, rq2_wptr : Gray read pointer and synchronized Gray write pointer
//     rinc           : pop request to the read-pointer block
//     m_stream       : output stream (m_valid, m_ready, m_data)
//     rlevel         : words held in FIFO memory (excludes buffered words)
//     ralmost_empty  : rlevel <= AE_THRESH
module afifo_rd_stage #(
  parameter int ADDRSIZE  = 4,
  parameter int DSIZE     = 8,
  parameter int AE_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DSIZE-1:0]      rdata,
  input  logic [ADDRSIZE:0]     rptr,
  input  logic [ADDRSIZE:0]     rq2_wptr,
  output logic                  rinc,
  afifo_rd_stage_if.master      m_stream,
  output logic [ADDRSIZE:0]     rlevel,
  output logic                  ralmost_empty
);

  localparam int PW = ADDRSIZE + 1;

  logic [1:0]       cnt_p0;
  logic [1:0]       cnt_nxt;
  logic             vld_p0;
  logic [DSIZE-1:0] head_p0;
  logic [DSIZE-1:0] skid_p0;
  logic [DSIZE-1:0] head_nxt;
  logic [DSIZE-1:0] skid_nxt;
  logic             pop;
  logic             deq;

  // Pop decision uses registered state only, so m_ready never reaches rinc.
  assign rinc = ~rempty & (cnt_p0 != 2'd2);
  assign pop  = rinc;
  assign deq  = vld_p0 & m_stream.m_ready;

  always_comb begin
    cnt_nxt  = cnt_p0;
    head_nxt = head_p0;
    skid_nxt = skid_p0;
    case (cnt_p0)
      2'd0: begin
        if (pop) begin
          head_nxt = rdata;
          cnt_nxt  = 2'd1;
        end
      end
      2'd1: begin
        if (pop && !deq) begin
          skid_nxt = rdata;
          cnt_nxt  = 2'd2;
        end else if (!pop && deq) begin
          cnt_nxt  = 2'd0;
        end else if (pop && deq) begin
          // Head leaves and the new word replaces it in the same cycle.
          head_nxt = rdata;
        end
      end
      2'd2: begin
        if (deq) begin
          head_nxt = skid_p0;
          cnt_nxt  = 2'd1;
        end
      end
      default: cnt_nxt = cnt_p0;
    endcase
  end

  // ---- stage p0: output buffer registers ----
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt_p0  <= 2'd0;
      vld_p0  <= 1'b0;
      head_p0 <= '0;
      skid_p0 <= '0;
    end else begin
      cnt_p0  <= cnt_nxt;
      vld_p0  <= (cnt_nxt != 2'd0);
      head_p0 <= head_nxt;
      skid_p0 <= skid_nxt;
    end
  end

  assign m_stream.m_valid = vld_p0;
  assign m_stream.m_data  = head_p0;

`ifdef AFIFO_RD_LEVEL_EN
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] level_nxt;
  logic          ae_nxt;
  logic [PW-1:0] level_p1;
  logic          ae_p1;

  // Modular subtraction absorbs pointer wrap; the extra MSB keeps full (2^ADDRSIZE) distinct from empty.
  always_comb begin
    level_nxt = gray2bin(rq2_wptr) - gray2bin(rptr);
    ae_nxt    = (level_nxt <= AE_T);
  end

  // ---- stage p1: level registers ----
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      level_p1 <= '0;
      ae_p1    <= 1'b1;
    end else begin
      level_p1 <= level_nxt;
      ae_p1    <= ae_nxt;
    end
  end

  assign rlevel        = level_p1;
  assign ralmost_empty = ae_p1;
`else
  logic unused_ptrs;
  assign unused_ptrs   = ^{rptr, rq2_wptr};
  assign rlevel        = '0;
  assign ralmost_empty = 1'b1;
`endif

endmodule
